// File: rtl/axi_burst_mem_slave_pkg.sv
// Shared types and helpers for the AXI4 burst memory slave.
package axi_burst_mem_slave_pkg;

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Only full-width FIXED/INCR bursts are served; anything else errors out.
  function automatic logic burst_legal(input logic [1:0] burst,
                                       input logic [SIZE_W-1:0] size,
                                       input logic [SIZE_W-1:0] lsb);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == lsb);
  endfunction

endpackage

// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 AW/W/B/AR/R channel bundle with master and slave views.
interface axi_burst_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_mem_slave_addr_gen.sv
// Next word index for a burst: FIXED holds, otherwise +1 modulo the memory depth.
module axi_burst_addr_gen
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int unsigned IDX_W = 7
) (
  input  logic [IDX_W-1:0] i_idx,
  input  burst_t           i_burst,
  output logic [IDX_W-1:0] o_idx_nxt
);

  always_comb begin
    o_idx_nxt = (i_burst == BURST_FIXED) ? i_idx : i_idx + IDX_W'(1);
  end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: independent write and read FSMs over one word array.
module axi_burst_mem_slave
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 128
) (
  input  logic                   clk,
  input  logic                   resetn,
  axi_burst_mem_slave_if.slave   s_axi
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_awaddr;
  logic [ADDR_WIDTH-1:0] w_araddr;
  logic [IDX_W-1:0]      w_aw_idx;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_aw_legal;
  logic                  w_ar_legal;

  // Upper address bits alias onto the same words.
  assign w_awaddr   = s_axi.awaddr;
  assign w_araddr   = s_axi.araddr;
  assign w_aw_idx   = IDX_W'(w_awaddr >> LSB);
  assign w_ar_idx   = IDX_W'(w_araddr >> LSB);
  assign w_aw_legal = burst_legal(s_axi.awburst, s_axi.awsize, SIZE_W'(LSB));
  assign w_ar_legal = burst_legal(s_axi.arburst, s_axi.arsize, SIZE_W'(LSB));

  // ---------------- write channel ----------------
  wr_state_t         r_wr_state, w_wr_state_nxt;
  logic [IDX_W-1:0]  r_wr_idx, w_wr_idx_nxt, w_wr_idx_adv;
  logic [LEN_W-1:0]  r_wr_len, w_wr_len_nxt;
  logic [LEN_W-1:0]  r_wr_cnt, w_wr_cnt_nxt;
  burst_t            r_wr_burst, w_wr_burst_nxt;
  logic              r_wr_legal, w_wr_legal_nxt;
  logic              r_awready, w_awready_nxt;
  logic              r_wready, w_wready_nxt;
  logic              r_bvalid, w_bvalid_nxt;
  resp_t             r_bresp, w_bresp_nxt;
  logic              w_wr_beat;
  logic              w_wr_len_hit;

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_wr_addr_gen (
    .i_idx     (r_wr_idx),
    .i_burst   (r_wr_burst),
    .o_idx_nxt (w_wr_idx_adv)
  );

  assign w_wr_beat    = (r_wr_state == W_DATA) && s_axi.wvalid && r_wready;
  assign w_wr_len_hit = (r_wr_cnt == r_wr_len);

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_idx_nxt   = r_wr_idx;
    w_wr_len_nxt   = r_wr_len;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_wr_burst_nxt = r_wr_burst;
    w_wr_legal_nxt = r_wr_legal;
    w_awready_nxt  = r_awready;
    w_wready_nxt   = r_wready;
    w_bvalid_nxt   = r_bvalid;
    w_bresp_nxt    = r_bresp;
    case (r_wr_state)
      W_IDLE: begin
        w_awready_nxt = 1'b1;
        if (s_axi.awvalid && r_awready) begin
          w_wr_idx_nxt   = w_aw_idx;
          w_wr_len_nxt   = s_axi.awlen;
          w_wr_burst_nxt = burst_t'(s_axi.awburst);
          w_wr_legal_nxt = w_aw_legal;
          w_wr_cnt_nxt   = '0;
          w_awready_nxt  = 1'b0;
          w_wready_nxt   = 1'b1;
          w_wr_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        if (w_wr_beat) begin
          // wlast and the beat count must agree; either one ends the burst.
          if (w_wr_len_hit || s_axi.wlast) begin
            w_wready_nxt   = 1'b0;
            w_bvalid_nxt   = 1'b1;
            w_bresp_nxt    = (r_wr_legal && (w_wr_len_hit == s_axi.wlast)) ? RESP_OKAY
                                                                            : RESP_SLVERR;
            w_wr_state_nxt = W_RESP;
          end else begin
            w_wr_cnt_nxt = r_wr_cnt + LEN_W'(1);
            w_wr_idx_nxt = w_wr_idx_adv;
          end
        end
      end
      W_RESP: begin
        if (r_bvalid && s_axi.bready) begin
          w_bvalid_nxt   = 1'b0;
          w_bresp_nxt    = RESP_OKAY;
          w_awready_nxt  = 1'b1;
          w_wr_state_nxt = W_IDLE;
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_state <= W_IDLE;
      r_wr_idx   <= '0;
      r_wr_len   <= '0;
      r_wr_cnt   <= '0;
      r_wr_burst <= BURST_FIXED;
      r_wr_legal <= 1'b0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_idx   <= w_wr_idx_nxt;
      r_wr_len   <= w_wr_len_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_wr_burst <= w_wr_burst_nxt;
      r_wr_legal <= w_wr_legal_nxt;
      r_awready  <= w_awready_nxt;
      r_wready   <= w_wready_nxt;
      r_bvalid   <= w_bvalid_nxt;
      r_bresp    <= w_bresp_nxt;
    end
  end

  // Memory is never cleared; illegal bursts only consume their beats.
  always_ff @(posedge clk) begin
    if (resetn && w_wr_beat && r_wr_legal) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) begin
          r_mem[r_wr_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_t         r_rd_state, w_rd_state_nxt;
  logic [IDX_W-1:0]  r_rd_idx, w_rd_idx_nxt, w_rd_idx_adv;
  logic [LEN_W-1:0]  r_rd_len, w_rd_len_nxt;
  logic [LEN_W-1:0]  r_rd_cnt, w_rd_cnt_nxt;
  burst_t            r_rd_burst, w_rd_burst_nxt;
  logic              r_rd_legal, w_rd_legal_nxt;
  logic              r_arready, w_arready_nxt;
  logic              r_rvalid, w_rvalid_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
  resp_t             r_rresp, w_rresp_nxt;
  logic              r_rlast, w_rlast_nxt;
  logic [DATA_WIDTH-1:0] w_ar_word;
  logic [DATA_WIDTH-1:0] w_rd_adv_word;

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_rd_addr_gen (
    .i_idx     (r_rd_idx),
    .i_burst   (r_rd_burst),
    .o_idx_nxt (w_rd_idx_adv)
  );

  // Reads sample the array before this edge's write lands, so they see old data.
  assign w_ar_word     = r_mem[w_ar_idx];
  assign w_rd_adv_word = r_mem[w_rd_idx_adv];

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_idx_nxt   = r_rd_idx;
    w_rd_len_nxt   = r_rd_len;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_rd_burst_nxt = r_rd_burst;
    w_rd_legal_nxt = r_rd_legal;
    w_arready_nxt  = r_arready;
    w_rvalid_nxt   = r_rvalid;
    w_rdata_nxt    = r_rdata;
    w_rresp_nxt    = r_rresp;
    w_rlast_nxt    = r_rlast;
    case (r_rd_state)
      R_IDLE: begin
        w_arready_nxt = 1'b1;
        if (s_axi.arvalid && r_arready) begin
          w_rd_idx_nxt   = w_ar_idx;
          w_rd_len_nxt   = s_axi.arlen;
          w_rd_burst_nxt = burst_t'(s_axi.arburst);
          w_rd_legal_nxt = w_ar_legal;
          w_rd_cnt_nxt   = '0;
          w_arready_nxt  = 1'b0;
          w_rvalid_nxt   = 1'b1;
          w_rdata_nxt    = w_ar_legal ? w_ar_word : '0;
          w_rresp_nxt    = w_ar_legal ? RESP_OKAY : RESP_SLVERR;
          w_rlast_nxt    = (s_axi.arlen == '0);
          w_rd_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (r_rvalid && s_axi.rready) begin
          if (r_rd_cnt == r_rd_len) begin
            w_rvalid_nxt   = 1'b0;
            w_rlast_nxt    = 1'b0;
            w_rdata_nxt    = '0;
            w_rresp_nxt    = RESP_OKAY;
            w_arready_nxt  = 1'b1;
            w_rd_state_nxt = R_IDLE;
          end else begin
            w_rd_cnt_nxt = r_rd_cnt + LEN_W'(1);
            w_rd_idx_nxt = w_rd_idx_adv;
            w_rdata_nxt  = r_rd_legal ? w_rd_adv_word : '0;
            w_rlast_nxt  = ((r_rd_cnt + LEN_W'(1)) == r_rd_len);
          end
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_state <= R_IDLE;
      r_rd_idx   <= '0;
      r_rd_len   <= '0;
      r_rd_cnt   <= '0;
      r_rd_burst <= BURST_FIXED;
      r_rd_legal <= 1'b0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rlast    <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_idx   <= w_rd_idx_nxt;
      r_rd_len   <= w_rd_len_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_rd_burst <= w_rd_burst_nxt;
      r_rd_legal <= w_rd_legal_nxt;
      r_arready  <= w_arready_nxt;
      r_rvalid   <= w_rvalid_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rresp    <= w_rresp_nxt;
      r_rlast    <= w_rlast_nxt;
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rlast   = r_rlast;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Randomized self-checking bench for axi_burst_mem_slave against a word-array model.
module tb_axi_burst_mem_slave;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned SW = DW / 8;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] WRAP = 2'b10;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] rd_data_q [$];
  logic [1:0]    rd_resp_q [$];
  logic          rd_last_q [$];
  logic          rd_lat_ok;
  int            rd_unstable;

  axi_burst_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  axi_burst_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .s_axi  (ifc)
  );

  function automatic logic is_legal(input logic [1:0] burst, input logic [2:0] size);
    return ((burst == FIXED) || (burst == INCR)) && (size == 3'd2);
  endfunction

  function automatic int widx(input logic [31:0] addr, input int i, input logic [1:0] burst);
    int base;
    base = int'((addr >> 2) % DEPTH);
    return (burst == FIXED) ? base : (base + i) % DEPTH;
  endfunction

  function automatic logic [DW-1:0] exp_rdata(input logic [31:0] addr, input int i,
                                              input logic [2:0] size, input logic [1:0] burst);
    return is_legal(burst, size) ? mdl[widx(addr, i, burst)] : '0;
  endfunction

  task automatic drive_idle();
    ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0; ifc.awvalid = 1'b0;
    ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0; ifc.bready = 1'b0;
    ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0; ifc.arburst = '0; ifc.arvalid = 1'b0;
    ifc.rready = 1'b0;
  endtask

  // Drives one write burst; the model absorbs each accepted beat of a legal burst.
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int last_beat, input logic rnd_strb,
                           input logic seq, input logic [31:0] seq_base,
                           output logic [1:0] resp, output int beats);
    int n;
    int i;
    logic done;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    ifc.awaddr = addr; ifc.awlen = 8'(len); ifc.awsize = size; ifc.awburst = burst;
    ifc.awvalid = 1'b1;
    n = 0;
    while (ifc.awready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL aw_timeout awready=%b required 1", ifc.awready);
    end
    @(negedge clk);
    ifc.awvalid = 1'b0;
    i = 0; done = 1'b0;
    while (!done) begin
      d = seq ? seq_base + 32'(i) : $urandom;
      s = rnd_strb ? SW'($urandom) : '1;
      ifc.wdata = d; ifc.wstrb = s; ifc.wlast = (i == last_beat); ifc.wvalid = 1'b1;
      n = 0;
      while (ifc.wready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
        checks++; errors++;
        $display("FAIL w_timeout beat=%0d wready=%b required 1", i, ifc.wready);
      end
      if (is_legal(burst, size))
        for (int b = 0; b < SW; b++)
          if (s[b]) mdl[widx(addr, i, burst)][8*b +: 8] = d[8*b +: 8];
      done = (i == len) || (i == last_beat);
      @(negedge clk);
      i++;
    end
    ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
    beats = i;
    n = 0;
    while (ifc.bvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL b_timeout bvalid=%b required 1", ifc.bvalid);
    end
    resp = ifc.bresp;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    ifc.bready = 1'b1;
    @(negedge clk);
    ifc.bready = 1'b0;
  endtask

  // Collects read beats; mode 0 rready=1, 1 alternating, 2 random. stop_at>=0 quits early.
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int mode, input int stop_at);
    int n;
    int got;
    int want;
    logic rr;
    logic stalled;
    logic [DW-1:0] sd;
    logic [1:0] sr;
    logic sl;
    rd_data_q.delete(); rd_resp_q.delete(); rd_last_q.delete();
    rd_unstable = 0;
    ifc.araddr = addr; ifc.arlen = 8'(len); ifc.arsize = size; ifc.arburst = burst;
    ifc.arvalid = 1'b1;
    n = 0;
    while (ifc.arready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL ar_timeout arready=%b required 1", ifc.arready);
    end
    @(negedge clk);
    ifc.arvalid = 1'b0;
    rd_lat_ok = ifc.rvalid;
    want = (stop_at >= 0) ? stop_at : len + 1;
    got = 0; n = 0; stalled = 1'b0; sd = '0; sr = '0; sl = 1'b0;
    while (got < want && n < 2000) begin
      if (stalled && (ifc.rvalid !== 1'b1 || ifc.rdata !== sd || ifc.rresp !== sr || ifc.rlast !== sl))
        rd_unstable++;
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom);
      ifc.rready = rr;
      stalled = 1'b0;
      if (ifc.rvalid === 1'b1 && rr) begin
        rd_data_q.push_back(ifc.rdata); rd_resp_q.push_back(ifc.rresp);
        rd_last_q.push_back(ifc.rlast);
        got++;
      end else if (ifc.rvalid === 1'b1) begin
        stalled = 1'b1; sd = ifc.rdata; sr = ifc.rresp; sl = ifc.rlast;
      end
      @(negedge clk);
      n++;
    end
    ifc.rready = 1'b0;
    if (got < want) begin
      checks++; errors++;
      $display("FAIL r_timeout beats=%0d required %0d", got, want);
    end
  endtask

  task automatic test_reset();
    logic [41:0] obs;
    drive_idle();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    obs = {ifc.awready, ifc.wready, ifc.bvalid, ifc.bresp, ifc.arready, ifc.rvalid,
           ifc.rresp, ifc.rlast, ifc.rdata};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h required 0", obs); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.awready, ifc.arready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready got=%b%b required 11", ifc.awready, ifc.arready);
    end
  endtask

  task automatic test_fill();
    logic [1:0] resp;
    int beats;
    axi_write(32'h0, DEPTH - 1, 3'd2, INCR, DEPTH - 1, 1'b0, 1'b0, 32'h0, resp, beats);
    checks++;
    if (resp !== OKAY || beats != DEPTH) begin
      errors++; $display("FAIL fill resp=%b beats=%0d required %b %0d", resp, beats, OKAY, DEPTH);
    end
  endtask

  task automatic test_incr_write();
    logic [1:0] resp;
    int beats;
    axi_write(32'h0, 7, 3'd2, INCR, 7, 1'b0, 1'b1, 32'd10, resp, beats);
    checks++;
    if (resp !== OKAY || beats != 8) begin
      errors++; $display("FAIL incr_write resp=%b beats=%0d required %b 8", resp, beats, OKAY);
    end
  endtask

  task automatic test_incr_read();
    axi_read(32'h0, 7, 3'd2, INCR, 0, -1);
    checks++;
    if (rd_lat_ok !== 1'b1) begin errors++; $display("FAIL incr_read_latency rvalid=%b required 1", rd_lat_ok); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= rd_data_q.size() || rd_data_q[i] !== 32'(10 + i) || rd_last_q[i] !== (i == 7)
          || rd_resp_q[i] !== OKAY) begin
        errors++;
        $display("FAIL incr_read beat%0d data=%h last=%b resp=%b required %h %b %b", i,
                 (i < rd_data_q.size()) ? rd_data_q[i] : 'x, (i < rd_last_q.size()) ? rd_last_q[i] : 1'bx,
                 (i < rd_resp_q.size()) ? rd_resp_q[i] : 2'bxx, 32'(10 + i), (i == 7), OKAY);
      end
    end
    checks++;
    if (ifc.rvalid !== 1'b0) begin errors++; $display("FAIL incr_read_end rvalid=%b required 0", ifc.rvalid); end
  endtask

  task automatic test_stall();
    axi_read(32'h40, 3, 3'd2, INCR, 1, -1);
    checks++;
    if (rd_unstable != 0) begin errors++; $display("FAIL stall_stable changes=%0d required 0", rd_unstable); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_data_q.size() || rd_data_q[i] !== exp_rdata(32'h40, i, 3'd2, INCR)
          || rd_last_q[i] !== (i == 3)) begin
        errors++;
        $display("FAIL stall_beat%0d data=%h last=%b required %h %b", i,
                 (i < rd_data_q.size()) ? rd_data_q[i] : 'x, (i < rd_last_q.size()) ? rd_last_q[i] : 1'bx,
                 exp_rdata(32'h40, i, 3'd2, INCR), (i == 3));
      end
    end
  endtask

  task automatic test_illegal();
    logic [1:0] resp;
    int beats;
    axi_write(32'h60, 3, 3'd2, WRAP, 3, 1'b0, 1'b0, 32'h0, resp, beats);
    checks++;
    if (resp !== SLVERR) begin errors++; $display("FAIL wrap_write resp=%b required %b", resp, SLVERR); end
    axi_read(32'h60, 3, 3'd2, INCR, 0, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_data_q.size() || rd_data_q[i] !== exp_rdata(32'h60, i, 3'd2, INCR)) begin
        errors++;
        $display("FAIL wrap_unchanged beat%0d data=%h required %h", i,
                 (i < rd_data_q.size()) ? rd_data_q[i] : 'x, exp_rdata(32'h60, i, 3'd2, INCR));
      end
    end
    axi_read(32'h60, 3, 3'd1, INCR, 0, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_data_q.size() || rd_data_q[i] !== '0 || rd_resp_q[i] !== SLVERR
          || rd_last_q[i] !== (i == 3)) begin
        errors++;
        $display("FAIL size_read beat%0d data=%h resp=%b required 0 %b", i,
                 (i < rd_data_q.size()) ? rd_data_q[i] : 'x,
                 (i < rd_resp_q.size()) ? rd_resp_q[i] : 2'bxx, SLVERR);
      end
    end
  endtask

  task automatic test_early_wlast();
    logic [1:0] resp;
    int beats;
    axi_write(32'h80, 5, 3'd2, INCR, 2, 1'b0, 1'b0, 32'h0, resp, beats);
    checks++;
    if (resp !== SLVERR || beats != 3) begin
      errors++; $display("FAIL early_wlast resp=%b beats=%0d required %b 3", resp, beats, SLVERR);
    end
    axi_write(32'h100, 1, 3'd2, INCR, 1, 1'b0, 1'b0, 32'h0, resp, beats);
    checks++;
    if (resp !== OKAY) begin errors++; $display("FAIL after_early resp=%b required %b", resp, OKAY); end
    axi_read(32'h80, 5, 3'd2, INCR, 0, -1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= rd_data_q.size() || rd_data_q[i] !== exp_rdata(32'h80, i, 3'd2, INCR)) begin
        errors++;
        $display("FAIL early_readback beat%0d data=%h required %h", i,
                 (i < rd_data_q.size()) ? rd_data_q[i] : 'x, exp_rdata(32'h80, i, 3'd2, INCR));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] resp;
    int beats;
    int len;
    logic [31:0] addr;
    logic [1:0] burst;
    for (int t = 0; t < 8; t++) begin
      addr  = (t == 0) ? 32'hFFFF_01F4 : ($urandom & 32'hFFFF_FFFC);
      len   = (t == 0) ? 5 : $urandom_range(0, 15);
      burst = $urandom_range(0, 1) ? INCR : FIXED;
      axi_write(addr, len, 3'd2, burst, len, 1'b1, 1'b0, 32'h0, resp, beats);
      checks++;
      if (resp !== OKAY) begin errors++; $display("FAIL rand_write%0d resp=%b required %b", t, resp, OKAY); end
      addr  = (t % 2 == 0) ? addr : ($urandom & 32'hFFFF_FFFC);
      len   = $urandom_range(0, 15);
      burst = $urandom_range(0, 1) ? INCR : FIXED;
      axi_read(addr, len, 3'd2, burst, 2, -1);
      checks++;
      if (rd_unstable != 0) begin errors++; $display("FAIL rand_stable%0d changes=%0d required 0", t, rd_unstable); end
      for (int i = 0; i <= len; i++) begin
        checks++;
        if (i >= rd_data_q.size() || rd_data_q[i] !== exp_rdata(addr, i, 3'd2, burst)
            || rd_last_q[i] !== (i == len) || rd_resp_q[i] !== OKAY) begin
          errors++;
          $display("FAIL rand_read%0d beat%0d data=%h last=%b required %h %b", t, i,
                   (i < rd_data_q.size()) ? rd_data_q[i] : 'x, (i < rd_last_q.size()) ? rd_last_q[i] : 1'bx,
                   exp_rdata(addr, i, 3'd2, burst), (i == len));
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [41:0] obs;
    axi_read(32'h0, 7, 3'd2, INCR, 0, 3);
    resetn = 1'b0;
    @(negedge clk);
    obs = {ifc.awready, ifc.wready, ifc.bvalid, ifc.bresp, ifc.arready, ifc.rvalid,
           ifc.rresp, ifc.rlast, ifc.rdata};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL midread_reset got=%h required 0", obs); end
    @(negedge clk);
    resetn = 1'b1;
    axi_read(32'h0, 7, 3'd2, INCR, 0, -1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= rd_data_q.size() || rd_data_q[i] !== exp_rdata(32'h0, i, 3'd2, INCR)
          || rd_last_q[i] !== (i == 7)) begin
        errors++;
        $display("FAIL post_reset beat%0d data=%h required %h", i,
                 (i < rd_data_q.size()) ? rd_data_q[i] : 'x, exp_rdata(32'h0, i, 3'd2, INCR));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_incr_write();
    test_incr_read();
    test_stall();
    test_illegal();
    test_early_wlast();
    test_random();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
